// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit serializer and receive deserializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  // Callers zero-extend their data word, which leaves the XOR unchanged.
  function automatic logic parity_f(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last clock cycle of each serial bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Pops bytes from the TX FIFO and shifts each one out on txd as an asynchronous serial frame.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              txd_q, txd_d;
  logic              tick;
  logic              baud_clr;

  // Every bit period starts from zero: the counter restarts on each state change.
  assign baud_clr = (state_d != state_q) || (state_q == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= MARK;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    done       = 1'b0;
    fifo_rd    = (state_q == IDLE) && tx_en && !fifo_empty && !rst;

    case (state_q)
      IDLE: begin
        if (fifo_rd) state_d = CAPT;
      end
      CAPT: begin
        shift_d    = fifo_rdata;
        parity_d   = parity_f(32'(fifo_rdata), PARITY_ODD != 0);
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        state_d    = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            stop_idx_d = 1'b0;
            state_d    = IDLE;
            done       = !rst;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from the upcoming state so it lines up with state_q.
    case (state_d)
      START:   txd_d = SPACE;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_q;
      default: txd_d = MARK;
    endcase
  end

  assign txd  = txd_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: four serializer variants (plain, even parity, odd parity, two stop bits) fed by FIFO models.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] seq;
    int          nb;
    bit          b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rst = 4'hF;
  logic [3:0] tx_en = 4'h0;
  logic [3:0] fifo_empty = 4'hF;
  logic [3:0] fifo_rd, txd, busy, done;
  logic [7:0] rdata [4];

  exp_t       exp_q [4][$];
  logic [7:0] fq [4][$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  logic [63:0] hist [4] = '{default: '1};
  int          rd_cyc [4] = '{default: 0};
  int          last_done [4] = '{default: -100};
  int          busy_cnt [4] = '{default: 0};
  bit          inflight [4] = '{default: 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst(rst[0]), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]), .fifo_rd(fifo_rd[0]),
    .fifo_rdata(rdata[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst[1]), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]), .fifo_rd(fifo_rd[1]),
    .fifo_rdata(rdata[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst[2]), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]), .fifo_rd(fifo_rd[2]),
    .fifo_rdata(rdata[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst[3]), .tx_en(tx_en[3]), .fifo_empty(fifo_empty[3]), .fifo_rd(fifo_rd[3]),
    .fifo_rdata(rdata[3]), .txd(txd[3]), .busy(busy[3]), .done(done[3]));

  // FIFO models: pop mid-cycle on a read so data is valid the following cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd[i] && fq[i].size() > 0) rdata[i] = fq[i].pop_front();
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) fifo_empty[i] <= (fq[i].size() == 0);
  end

  task automatic checkOutput(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  task automatic failNote(input string name, input int inst);
    total++;
    bad++;
    $display("[TB] FAIL %s inst%0d: got event expected none (cycle %0d)", name, inst, cyc);
  endtask

  // Queue a byte into a FIFO model and its hand-computed frame (first bit sent is the MSB of seq).
  task automatic applyStimulus(input int inst, input logic [7:0] data, input logic [15:0] seq, input int nb, input bit b2b);
    exp_t e;
    e.seq = seq;
    e.nb  = nb;
    e.b2b = b2b;
    fq[inst].push_back(data);
    exp_q[inst].push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() != 0 || fq[i].size() != 0 || inflight[i]) p = 1'b1;
    end
    return p;
  endfunction

  task automatic waitDrain(input int limit);
    int c = 0;
    while (pending() && c < limit) begin
      step(1);
      c++;
    end
    if (pending()) failNote("drain_timeout", 0);
  endtask

  task automatic waitRd(input int inst, input int limit);
    int c = 0;
    while (!fifo_rd[inst] && c < limit) begin
      step(1);
      c++;
    end
    if (!fifo_rd[inst]) failNote("rd_timeout", inst);
  endtask

  // Monitor: frame bookkeeping per instance, compared against the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t        e;
    int          f;
    logic [63:0] expv;
    logic [63:0] mask;
    for (int i = 0; i < 4; i++) begin
      hist[i] = {hist[i][62:0], txd[i]};
      if (rst[i]) begin
        if (inflight[i]) begin
          if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
          checkOutput("abort_no_done", i, 64'(done[i]), 64'd0);
          inflight[i] = 1'b0;
        end
      end else begin
        if (fifo_rd[i]) begin
          if (inflight[i]) failNote("double_pop", i);
          else if (exp_q[i].size() == 0) failNote("unexpected_pop", i);
          else begin
            if (exp_q[i][0].b2b) checkOutput("b2b_gap", i, 64'(cyc - last_done[i]), 64'd1);
            rd_cyc[i]   = cyc;
            busy_cnt[i] = 0;
            inflight[i] = 1'b1;
          end
        end
        if (inflight[i] && busy[i]) busy_cnt[i]++;
        if (done[i]) begin
          if (!inflight[i] || exp_q[i].size() == 0) failNote("spurious_done", i);
          else begin
            e    = exp_q[i].pop_front();
            f    = e.nb * CPB;
            expv = '1;
            for (int k = 0; k < f; k++) expv[k] = e.seq[e.nb - 1 - (f - 1 - k) / CPB];
            mask = (64'd1 << (f + 2)) - 64'd1;
            checkOutput("done_latency", i, 64'(cyc - rd_cyc[i]), 64'(f + 1));
            checkOutput("busy_cycles", i, 64'(busy_cnt[i]), 64'(f + 1));
            checkOutput("frame_bits", i, hist[i] & mask, expv & mask);
            last_done[i] = cyc;
            inflight[i]  = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog inst0: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int viol;
    step(3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset_txd", i, 64'(txd[i]), 64'd1);
      checkOutput("reset_busy", i, 64'(busy[i]), 64'd0);
      checkOutput("reset_done", i, 64'(done[i]), 64'd0);
      checkOutput("reset_rd", i, 64'(fifo_rd[i]), 64'd0);
    end
    rst   = 4'h0;
    tx_en = 4'hF;

    // Empty FIFO: line must stay idle.
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (fifo_rd[0] || !txd[0] || busy[0]) viol++;
    end
    checkOutput("idle_empty", 0, 64'(viol), 64'd0);

    // Data waiting but transmitter disabled.
    tx_en[0] = 1'b0;
    applyStimulus(0, 8'hA5, 16'b0101001011, 10, 1'b0);
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (fifo_rd[0] || !txd[0] || busy[0]) viol++;
    end
    checkOutput("idle_disabled", 0, 64'(viol), 64'd0);
    tx_en[0] = 1'b1;
    waitDrain(200);

    // Back-to-back pairs on every variant.
    applyStimulus(0, 8'h55, 16'b0101010101, 10, 1'b0);
    applyStimulus(0, 8'hAA, 16'b0010101011, 10, 1'b1);
    applyStimulus(1, 8'h07, 16'b01110000011, 11, 1'b0);
    applyStimulus(1, 8'h03, 16'b01100000001, 11, 1'b1);
    applyStimulus(2, 8'h03, 16'b01100000011, 11, 1'b0);
    applyStimulus(2, 8'h07, 16'b01110000001, 11, 1'b1);
    applyStimulus(3, 8'h00, 16'b00000000011, 11, 1'b0);
    applyStimulus(3, 8'h81, 16'b01000000111, 11, 1'b1);
    waitDrain(400);

    // tx_en dropped mid-frame: current frame finishes, no further pop.
    applyStimulus(0, 8'h3C, 16'b0001111001, 10, 1'b0);
    applyStimulus(0, 8'hC3, 16'b0110000111, 10, 1'b0);
    waitRd(0, 20);
    step(10);
    tx_en[0] = 1'b0;
    viol = 0;
    for (int c = 0; c < 120; c++) begin
      step(1);
      if (fifo_rd[0]) viol++;
    end
    checkOutput("no_pop_disabled", 0, 64'(viol), 64'd0);
    checkOutput("frame_finished", 0, 64'(busy[0]), 64'd0);
    tx_en[0] = 1'b1;
    waitDrain(200);

    // Reset mid-DATA with FIFO non-empty: rst high across cycles N+20 and N+21.
    applyStimulus(0, 8'hE1, 16'b0100001111, 10, 1'b0);
    applyStimulus(0, 8'h5A, 16'b0010110101, 10, 1'b0);
    waitRd(0, 20);
    step(20);
    rst[0] = 1'b1;
    step(1);
    checkOutput("rst_txd", 0, 64'(txd[0]), 64'd1);
    checkOutput("rst_busy", 0, 64'(busy[0]), 64'd0);
    checkOutput("rst_rd", 0, 64'(fifo_rd[0]), 64'd0);
    checkOutput("rst_done", 0, 64'(done[0]), 64'd0);
    step(1);
    rst[0] = 1'b0;
    #1;
    checkOutput("rst_repop", 0, 64'(fifo_rd[0]), 64'd1);
    waitDrain(200);

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
